// File: rtl/tiger_trace_tap.sv
// tiger_trace_tap: instruction-trace front end for the Tiger pipeline.
// Stall-aware pc/ins delay line, STARTINGPC..FINISHPC measurement window
// with cycle/stall counters, per-cache stuck watchdogs, and a show-ahead
// FIFO of retired {pc, ins} pairs drained by an on-chip debug reader.
module tiger_trace_tap #(
    parameter logic [31:0] STARTINGPC  = 32'h0080_0000,
    parameter logic [31:0] FINISHPC    = 32'h0080_0004,
    parameter int          STALL_LIMIT = 1000,
    parameter int          FIFO_AW     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] ins,
    input  logic        insValid,
    input  logic        iCacheStall,
    input  logic        dCacheStall,
    output logic [31:0] pc_r,
    output logic [31:0] pc_rr,
    output logic [31:0] pc_rrr,
    output logic [31:0] ins_r,
    output logic [31:0] ins_rr,
    output logic        insValid_r,
    output logic        insValid_rr,
    output logic        running,
    output logic        done,
    output logic [63:0] cycle_count,
    output logic [31:0] istall_cycles,
    output logic [31:0] dstall_cycles,
    output logic        icache_stuck,
    output logic        dcache_stuck,
    output logic        missed_ins,
    output logic        trace_valid,
    output logic [63:0] trace_data,
    input  logic        trace_ready,
    output logic        trace_overflow,
    output logic [15:0] trace_dropped
);

    localparam int              DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_C = (FIFO_AW+1)'(DEPTH);
    localparam logic [9:0]      LIM     = 10'(STALL_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    logic               r_done;
    logic [31:0]        r_pc_r, r_pc_rr, r_pc_rrr, r_ins_r, r_ins_rr;
    logic               r_v_r, r_v_rr;
    logic [63:0]        r_cyc;
    logic [31:0]        r_istall, r_dstall;
    logic [9:0]         r_icnt, r_dcnt;
    logic               r_istuck, r_dstuck;
    logic               r_missed;
    logic [63:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_ovf;
    logic [15:0]        r_drop;

    logic w_adv, w_run, w_wr, w_rd, w_full, w_wr_ok;

    assign w_adv   = ~(iCacheStall | dCacheStall);
    assign w_run   = (r_state == S_RUN);
    assign w_wr    = w_run & w_adv & r_v_rr;
    assign w_rd    = trace_valid & trace_ready;
    assign w_full  = (r_count == FULL_C);
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign w_wr_ok = w_wr & (~w_full | w_rd);

    // Delay line: shifts only when the pipeline advances.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_r  <= '0; r_pc_rr <= '0; r_pc_rrr <= '0;
            r_ins_r <= '0; r_ins_rr <= '0;
            r_v_r   <= 1'b0; r_v_rr <= 1'b0;
        end else if (w_adv) begin
            r_pc_r  <= pc;      r_pc_rr  <= r_pc_r; r_pc_rrr <= r_pc_rr;
            r_ins_r <= ins;     r_ins_rr <= r_ins_r;
            r_v_r   <= insValid; r_v_rr  <= r_v_r;
        end
    end

    // Measurement window FSM; done is registered on the RUN->DONE edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE:  if (pc == STARTINGPC) r_state <= S_RUN;
                S_RUN:   if (pc == FINISHPC) begin
                             r_state <= S_DONE;
                             r_done  <= 1'b1;
                         end
                default: r_state <= S_DONE;
            endcase
        end
    end

    // Window counters: cycles in RUN (wrapping) and saturating stall counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cyc    <= '0;
            r_istall <= '0;
            r_dstall <= '0;
        end else if (w_run) begin
            r_cyc <= r_cyc + 64'd1;
            if (iCacheStall && r_istall != '1) r_istall <= r_istall + 32'd1;
            if (dCacheStall && r_dstall != '1) r_dstall <= r_dstall + 32'd1;
        end
    end

    // Stuck-cache watchdogs: consecutive-stall run length, flag is sticky.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_icnt <= '0; r_istuck <= 1'b0;
            r_dcnt <= '0; r_dstuck <= 1'b0;
        end else begin
            if (iCacheStall) begin
                if (r_icnt != LIM) r_icnt <= r_icnt + 10'd1;
                if (r_icnt + 10'd1 == LIM || r_icnt == LIM) r_istuck <= 1'b1;
            end else begin
                r_icnt <= '0;
            end
            if (dCacheStall) begin
                if (r_dcnt != LIM) r_dcnt <= r_dcnt + 10'd1;
                if (r_dcnt + 10'd1 == LIM || r_dcnt == LIM) r_dstuck <= 1'b1;
            end else begin
                r_dcnt <= '0;
            end
        end
    end

    // Flag a fetch that moved on without ever presenting a valid instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_missed <= 1'b0;
        else       r_missed <= w_adv & (pc != r_pc_r) & ~insValid;
    end

    // Trace FIFO: pointers wrap modulo depth, drops are counted when full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_drop   <= '0;
        end else begin
            if (w_wr_ok) begin
                r_mem[r_wr_ptr] <= {r_pc_rr, r_ins_rr};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr_ok && !w_rd)      r_count <= r_count + 1'b1;
            else if (!w_wr_ok && w_rd) r_count <= r_count - 1'b1;
            if (w_wr && !w_wr_ok) begin
                r_ovf <= 1'b1;
                if (r_drop != '1) r_drop <= r_drop + 16'd1;
            end
        end
    end

    assign pc_r           = r_pc_r;
    assign pc_rr          = r_pc_rr;
    assign pc_rrr         = r_pc_rrr;
    assign ins_r          = r_ins_r;
    assign ins_rr         = r_ins_rr;
    assign insValid_r     = r_v_r;
    assign insValid_rr    = r_v_rr;
    assign running        = w_run;
    assign done           = r_done;
    assign cycle_count    = r_cyc;
    assign istall_cycles  = r_istall;
    assign dstall_cycles  = r_dstall;
    assign icache_stuck   = r_istuck;
    assign dcache_stuck   = r_dstuck;
    assign missed_ins     = r_missed;
    assign trace_valid    = (r_count != '0);
    assign trace_data     = r_mem[r_rd_ptr];
    assign trace_overflow = r_ovf;
    assign trace_dropped  = r_drop;

endmodule

// File: tb/tb_tiger_trace_tap.sv
// Bench for tiger_trace_tap: directed steps plus a random phase, all
// outputs compared every cycle against a queue-based reference model.
module tb_tiger_trace_tap;

    localparam logic [31:0] START = 32'h0080_0000;
    localparam logic [31:0] FIN   = 32'h0080_0004;
    localparam int          LIM   = 1000;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, ins;
    logic        insValid, ic, dc, tr_ready;

    logic [31:0] d_pc_r, d_pc_rr, d_pc_rrr, d_ins_r, d_ins_rr;
    logic        d_v_r, d_v_rr, d_running, d_done;
    logic [63:0] d_cyc;
    logic [31:0] d_is, d_ds;
    logic        d_istk, d_dstk, d_missed, d_tvalid, d_ovf;
    logic [63:0] d_tdata;
    logic [15:0] d_drop;

    int n_checks = 0;
    int n_err    = 0;

    tiger_trace_tap dut (
        .clk(clk), .reset(reset), .pc(pc), .ins(ins), .insValid(insValid),
        .iCacheStall(ic), .dCacheStall(dc),
        .pc_r(d_pc_r), .pc_rr(d_pc_rr), .pc_rrr(d_pc_rrr),
        .ins_r(d_ins_r), .ins_rr(d_ins_rr),
        .insValid_r(d_v_r), .insValid_rr(d_v_rr),
        .running(d_running), .done(d_done), .cycle_count(d_cyc),
        .istall_cycles(d_is), .dstall_cycles(d_ds),
        .icache_stuck(d_istk), .dcache_stuck(d_dstk), .missed_ins(d_missed),
        .trace_valid(d_tvalid), .trace_data(d_tdata), .trace_ready(tr_ready),
        .trace_overflow(d_ovf), .trace_dropped(d_drop)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] h_pc[$], h_ins[$];
    logic        h_v[$];
    bit          m_run, m_fin, m_done, m_missed, m_istk, m_dstk, m_ovf;
    logic [63:0] m_cyc;
    logic [31:0] m_is, m_ds;
    int          m_icnt, m_dcnt, m_drop;
    logic [63:0] m_q[$];

    task automatic model_reset();
        h_pc = '{32'd0, 32'd0, 32'd0};
        h_ins = '{32'd0, 32'd0, 32'd0};
        h_v = '{1'b0, 1'b0, 1'b0};
        m_run = 0; m_fin = 0; m_done = 0; m_missed = 0;
        m_istk = 0; m_dstk = 0; m_ovf = 0;
        m_cyc = '0; m_is = '0; m_ds = '0;
        m_icnt = 0; m_dcnt = 0; m_drop = 0;
        m_q.delete();
    endtask

    // One clock edge of the intended behaviour, from the current inputs.
    task automatic model_edge();
        bit          adv = !(ic || dc);
        bit          rd  = (m_q.size() != 0) && tr_ready;
        int          occ = m_q.size();
        bit          wr  = m_run && adv && h_v[1];
        logic [63:0] wd  = {h_pc[1], h_ins[1]};
        m_missed = adv && (pc != h_pc[2]) && !insValid;
        m_done = 0;
        if (m_run) begin
            m_cyc = m_cyc + 64'd1;
            if (ic && m_is != 32'hFFFF_FFFF) m_is = m_is + 32'd1;
            if (dc && m_ds != 32'hFFFF_FFFF) m_ds = m_ds + 32'd1;
        end
        if (!m_run && !m_fin && pc == START) m_run = 1;
        else if (m_run && pc == FIN) begin m_run = 0; m_fin = 1; m_done = 1; end
        if (rd) void'(m_q.pop_front());
        if (wr) begin
            if (occ < DEPTH || rd) m_q.push_back(wd);
            else begin m_ovf = 1; if (m_drop != 16'hFFFF) m_drop++; end
        end
        m_icnt = ic ? ((m_icnt + 1 > LIM) ? LIM : m_icnt + 1) : 0;
        m_dcnt = dc ? ((m_dcnt + 1 > LIM) ? LIM : m_dcnt + 1) : 0;
        if (m_icnt == LIM) m_istk = 1;
        if (m_dcnt == LIM) m_dstk = 1;
        if (adv) begin
            h_pc.push_back(pc);  void'(h_pc.pop_front());
            h_ins.push_back(ins); void'(h_ins.pop_front());
            h_v.push_back(insValid); void'(h_v.pop_front());
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pc_r", 64'(d_pc_r), 64'(h_pc[2]));
        chk("pc_rr", 64'(d_pc_rr), 64'(h_pc[1]));
        chk("pc_rrr", 64'(d_pc_rrr), 64'(h_pc[0]));
        chk("ins_r", 64'(d_ins_r), 64'(h_ins[2]));
        chk("ins_rr", 64'(d_ins_rr), 64'(h_ins[1]));
        chk("v_r", 64'(d_v_r), 64'(h_v[2]));
        chk("v_rr", 64'(d_v_rr), 64'(h_v[1]));
        chk("running", 64'(d_running), 64'(m_run));
        chk("done", 64'(d_done), 64'(m_done));
        chk("cycle_count", d_cyc, m_cyc);
        chk("istall", 64'(d_is), 64'(m_is));
        chk("dstall", 64'(d_ds), 64'(m_ds));
        chk("istuck", 64'(d_istk), 64'(m_istk));
        chk("dstuck", 64'(d_dstk), 64'(m_dstk));
        chk("missed", 64'(d_missed), 64'(m_missed));
        chk("tvalid", 64'(d_tvalid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) chk("tdata", d_tdata, m_q[0]);
        chk("overflow", 64'(d_ovf), 64'(m_ovf));
        chk("dropped", 64'(d_drop), 64'(m_drop));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        pc = 0; ins = 0; insValid = 0; ic = 0; dc = 0; tr_ready = 0;
    endtask

    // Asynchronous reset mid-cycle: outputs must clear without a clock edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst_running", 64'(d_running), 64'd0);
        chk("rst_cycles", d_cyc, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
    endtask

    function automatic logic [31:0] rpc();
        return $urandom & 32'h000F_FFFC;
    endfunction

    initial begin
        int          nrun, ndone;
        logic [31:0] hold_pc;
        logic [63:0] sent[$];
        int          drop0;

        reset = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // Delay line after reset with pc=1..5, no stalls
        for (int i = 1; i <= 5; i++) begin pc = i; ins = $urandom; step(); end
        chk("t1_pc_r", 64'(d_pc_r), 64'd5);
        chk("t1_pc_rr", 64'(d_pc_rr), 64'd4);
        chk("t1_pc_rrr", 64'(d_pc_rrr), 64'd3);
        chk("t1_running", 64'(d_running), 64'd0);
        chk("t1_tvalid", 64'(d_tvalid), 64'd0);

        // Measurement window: START, 10 cycles, FINISH, then frozen
        nrun = 0; ndone = 0;
        pc = START; step(); nrun += d_running;
        for (int i = 0; i < 10; i++) begin
            pc = rpc(); ins = $urandom; insValid = $urandom_range(0, 1);
            step(); nrun += d_running; ndone += d_done;
        end
        pc = FIN; step(); nrun += d_running; ndone += d_done;
        for (int i = 0; i < 20; i++) begin
            pc = (i == 3) ? START : rpc(); step();
            nrun += d_running; ndone += d_done;
        end
        chk("win_run_cycles", 64'(nrun), 64'd11);
        chk("win_done_pulses", 64'(ndone), 64'd1);
        chk("win_cycle_count", d_cyc, 64'd11);

        // Stalls in RUN, then the stuck watchdog
        do_reset();
        pc = START; step();
        pc = rpc(); step();
        hold_pc = d_pc_r;
        dc = 1;
        for (int i = 0; i < 5; i++) begin pc = rpc(); step(); end
        chk("stall_hold_pc", 64'(d_pc_r), 64'(hold_pc));
        chk("stall_dcycles", 64'(d_ds), 64'd5);
        dc = 0; step();
        dc = 1;
        for (int i = 1; i <= 1000; i++) begin
            pc = rpc(); step();
            if (i == 999)  chk("stuck_999", 64'(d_dstk), 64'd0);
            if (i == 1000) chk("stuck_1000", 64'(d_dstk), 64'd1);
        end
        dc = 0;
        for (int i = 0; i < 3; i++) step();
        chk("stuck_sticky", 64'(d_dstk), 64'd1);

        // Trace FIFO fill, overflow, drain
        do_reset();
        pc = START; step();
        sent.delete();
        for (int i = 0; i < 19; i++) begin
            pc = rpc(); ins = $urandom; insValid = 1;
            sent.push_back({pc, ins});
            step();
        end
        insValid = 0;
        for (int i = 0; i < 3; i++) begin pc = rpc(); step(); end
        chk("ovf_dropped", 64'(d_drop), 64'd3);
        chk("ovf_flag", 64'(d_ovf), 64'd1);
        tr_ready = 1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_valid", 64'(d_tvalid), 64'd1);
            chk("drain_data", d_tdata, sent[i]);
            step();
        end
        chk("drain_empty", 64'(d_tvalid), 64'd0);

        // Full FIFO with simultaneous read and write
        tr_ready = 0;
        drop0 = m_drop;
        for (int i = 0; i < 26; i++) begin
            pc = rpc(); ins = $urandom; insValid = 1;
            tr_ready = (m_q.size() == DEPTH);
            step();
            if (i > 20) begin
                chk("full_rw_dropped", 64'(d_drop), 64'(drop0));
                chk("full_rw_occ", 64'(m_q.size()), 64'(DEPTH));
            end
        end
        insValid = 0; tr_ready = 1;
        for (int i = 0; i < 20; i++) step();

        // missed_ins pulse
        do_reset();
        pc = 32'h10; insValid = 1; step();
        pc = 32'h14; insValid = 0; step();
        chk("missed_pulse", 64'(d_missed), 64'd1);
        insValid = 1; step();
        chk("missed_clear", 64'(d_missed), 64'd0);

        // Reset in the middle of RUN
        pc = START; step();
        for (int i = 0; i < 6; i++) begin
            pc = rpc(); ins = $urandom; insValid = 1;
            ic = ($urandom_range(0, 3) == 0); step();
        end
        do_reset();
        chk("midrst_dropped", 64'(d_drop), 64'd0);

        // Random phase
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 11))
                0:       pc = START;
                1:       pc = FIN;
                default: pc = rpc();
            endcase
            ins = $urandom; insValid = ($urandom_range(0, 3) != 0);
            ic = ($urandom_range(0, 5) == 0);
            dc = ($urandom_range(0, 5) == 0);
            tr_ready = ($urandom_range(0, 2) == 0);
            step();
            if (i == 300) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/tiger_trace_tap.md
Name: tiger_trace_tap

Overview:
Synthesizable instruction-trace front end for the Tiger pipeline. It registers the fetch-stage pc/ins/insValid into a stall-aware delay line, which feeds the simulation-only execution monitor. It also tracks the STARTINGPC..FINISHPC measurement window with cycle and stall counters and cache-stuck watchdogs. Retired {pc, ins} pairs are buffered in a FIFO that an on-chip debug reader drains.

Parameters:
STARTINGPC, 32'h00800000, pc value that opens the measurement window
FINISHPC, 32'h00800004, pc value that closes the measurement window
STALL_LIMIT, 1000, consecutive stall cycles that flag a stuck cache (10-bit, ≤1023)
FIFO_AW, 4, trace FIFO address width; depth = 2**FIFO_AW

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pc  in  32  current fetch pc
ins  in  32  instruction at pc
insValid  in  1  ins is valid
iCacheStall  in  1  icache stalling pipeline
dCacheStall  in  1  dcache stalling pipeline
pc_r, pc_rr, pc_rrr  out  32 each  pc delayed 1/2/3 advances
ins_r, ins_rr  out  32 each  ins delayed 1/2 advances
insValid_r, insValid_rr  out  1 each  insValid delayed 1/2 advances
running  out  1  window open
done  out  1  one-cycle pulse on window close
cycle_count  out  64  cycles spent in RUN
istall_cycles, dstall_cycles  out  32 each  stall cycles in RUN, saturating
icache_stuck, dcache_stuck  out  1 each  sticky watchdog flags
missed_ins  out  1  pulse: pc changed while insValid=0
trace_valid  out  1  FIFO non-empty
trace_data  out  64  {pc, ins} at FIFO head (show-ahead)
trace_ready  in  1  reader pops head when trace_valid & trace_ready
trace_overflow  out  1  sticky: an entry was dropped
trace_dropped  out  16  dropped-entry count, saturating

Behaviour:
- Reset (async, any time, including mid-window): all outputs and internal state go to 0; FSM goes to IDLE; FIFO is emptied.
- adv = ~(iCacheStall | dCacheStall). When adv=1: pc_r<=pc, pc_rr<=pc_r, pc_rrr<=pc_rr, ins_r<=ins, ins_rr<=ins_r, insValid_r<=insValid, insValid_rr<=insValid_r. When adv=0: all delay registers hold.
- Window FSM has three states: IDLE, RUN, DONE.
  - IDLE->RUN when pc==STARTINGPC.
  - RUN->DONE when pc==FINISHPC. done pulses for exactly one cycle, registered on that transition.
  - DONE is held until reset.
  - If STARTINGPC==FINISHPC, IDLE goes only to RUN in that cycle.
  - running = (state==RUN).
- cycle_count increments every cycle the FSM is in RUN, including the cycle of the RUN->DONE transition. It freezes in DONE and wraps at 2^64.
- istall_cycles / dstall_cycles increment in RUN when the respective stall is high; they saturate at 32'hFFFFFFFF.
- Watchdog: a per-cache 10-bit run counter increments while its stall input is high and clears the cycle the stall is low. When the counter reaches STALL_LIMIT, the stuck flag sets (sticky until reset) and the counter holds. The watchdog is active in all FSM states.
- missed_ins is registered and pulses one cycle after a cycle with adv & (pc != pc_r) & ~insValid.
- Trace write: wr = running & adv & insValid_rr. The data written is {pc_rr, ins_rr}.
- Trace read: rd = trace_valid & trace_ready. The head advances on the next edge.
- Full handling:
  - When full and rd=1, a simultaneous wr is accepted.
  - When full and rd=0, wr is dropped: trace_overflow sets and trace_dropped increments, saturating at 16'hFFFF.
- Empty: trace_valid=0 and trace_data is don't-care; a simultaneous rd cannot occur.
- Occupancy counter width is FIFO_AW+1. Pointers wrap modulo the depth.

Test Plan:
- Reset is released with pc=0 and adv=1 for 5 cycles, with pc=1,2,3,4,5 -> pc_r=5, pc_rr=4, pc_rrr=3; running=0; trace_valid=0.
- pc=STARTINGPC, then 10 cycles, then pc=FINISHPC -> running is 1 for 11 cycles; done pulses once; cycle_count=11 and stays 11 for 20 further cycles.
- In RUN, dCacheStall held for 5 cycles -> delay line holds; dstall_cycles=5. Then held for 1000 cycles -> dcache_stuck=1 on cycle 1000 and remains set after the stall drops.
- In RUN, 16 valid instructions with trace_ready=0 -> 16 entries stored; 3 more -> trace_dropped=3, trace_overflow=1. Draining returns the first 16 {pc, ins} in order.
- FIFO full with trace_ready=1 and a write in the same cycle -> occupancy stays 16 and trace_dropped is unchanged.
- pc changes 0x10->0x14 with insValid=0 -> missed_ins pulses exactly one cycle. Asserting reset mid-RUN -> all counters and flags are 0 immediately and the FSM is IDLE.
